mem_req_arbiter: RTL

// Shares a single sram-like memory port between the instruction-fetch requester (read-only)
// and the data-access requester of cpu_core. It selects one requester per address handshake
// and tracks outstanding requests in an in-order ID FIFO. Each mem_data_ok is returned to the

---
 rtl/mem_req_arbiter_pkg.sv | 23 ++
 rtl/mem_req_arbiter_id_fifo.sv | 62 ++++++
 rtl/mem_req_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the inst/data memory-port arbiter.
//   ARB_ID_*  : 1-bit requester id stored per outstanding request
//   mem_cmd_t : downstream address-phase command bundle
//   ptr_w     : pointer width for a FIFO of a given depth (min 1 bit)
package mem_req_arbiter_pkg;

  localparam logic       ARB_ID_INST = 1'b0;
  localparam logic       ARB_ID_DATA = 1'b1;
  localparam logic [1:0] SIZE_WORD   = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order 1-bit id FIFO recording which requester owns each outstanding
// memory request.
//   clk, resetn : clock, async active-low reset
//   i_push/i_din: enqueue id
//   i_pop       : dequeue head (ignored when empty)
//   o_head      : id at the head
//   o_cnt       : entries held, 0..DEPTH
//   o_full      : o_cnt == DEPTH
// Push while full is accepted only together with a pop.
module arb_id_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic          i_din,
  input  logic          i_pop,
  output logic          o_head,
  output logic [CW-1:0] o_cnt,
  output logic          o_full
);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_pop_ok, w_push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_cnt     = r_cnt;
  assign o_head    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop & (r_cnt != '0);
  assign w_push_ok = i_push & (!o_full | w_pop_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop_ok) r_rptr <= ptr_inc(r_rptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between instruction fetch (read-only)
// and data access. One requester is selected per address handshake; the
// owner of every accepted request is queued so each in-order mem_data_ok
// is routed back to the right side.
//   inst_*  : fetch request/ack (word reads only)
//   data_*  : load/store request/ack
//   rsp_rdata : shared read-data bus (= mem_rdata)
//   mem_*   : downstream port; mem_data_ok strictly in request order
// Address phase and response routing are combinational (zero latency).
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rsp_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  // Lock keeps the downstream request stable while mem_addr_ok is low.
  localparam logic [0:0] ST_FREE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]    r_state;
  logic          r_lock_sel;
  logic [SW-1:0] r_starve;

  logic          w_lock_live, w_starved, w_sel, w_hs;
  logic          w_full, w_head;
  logic [CW-1:0] w_cnt;
  mem_cmd_t      w_cmd;

  // A locked requester that dropped its request (illegal) releases the lock
  // immediately so the other side is not blocked.
  assign w_lock_live = (r_state == ST_LOCK) &
                       ((r_lock_sel == ARB_ID_DATA) ? data_req : inst_req);
  assign w_starved   = inst_req & (r_starve == SW'(STARVE_MAX));

  always_comb begin
    w_sel = ARB_ID_INST;
    if (w_lock_live)                 w_sel = r_lock_sel;
    else if (data_req && !w_starved) w_sel = ARB_ID_DATA;
    else                             w_sel = ARB_ID_INST;
  end

  always_comb begin
    w_cmd = '{wr: 1'b0, size: SIZE_WORD, wstrb: 4'b0, addr: inst_addr, wdata: 32'b0};
    if (w_sel == ARB_ID_DATA)
      w_cmd = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                addr: data_addr, wdata: data_wdata};
  end

  assign mem_req   = (inst_req | data_req) & !w_full;
  assign mem_wr    = w_cmd.wr;
  assign mem_size  = w_cmd.size;
  assign mem_wstrb = w_cmd.wstrb;
  assign mem_addr  = w_cmd.addr;
  assign mem_wdata = w_cmd.wdata;

  assign w_hs         = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_hs & (w_sel == ARB_ID_INST);
  assign data_addr_ok = w_hs & (w_sel == ARB_ID_DATA);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_FREE;
      r_lock_sel <= ARB_ID_INST;
      r_starve   <= '0;
    end else begin
      if (w_hs) begin
        r_state <= ST_FREE;
      end else if (mem_req) begin
        r_state    <= ST_LOCK;
        r_lock_sel <= w_sel;
      end else begin
        r_state <= ST_FREE;
      end

      if (w_hs) begin
        if (w_sel == ARB_ID_INST)
          r_starve <= '0;
        else if (inst_req && (r_starve != SW'(STARVE_MAX)))
          r_starve <= r_starve + 1'b1;
      end
    end
  end

  arb_id_fifo #(.DEPTH(MAX_OUT)) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .i_push (w_hs),
    .i_din  (w_sel),
    .i_pop  (mem_data_ok),
    .o_head (w_head),
    .o_cnt  (w_cnt),
    .o_full (w_full)
  );

  // Responses with nothing outstanding are dropped.
  assign inst_data_ok = mem_data_ok & (w_cnt != '0) & (w_head == ARB_ID_INST);
  assign data_data_ok = mem_data_ok & (w_cnt != '0) & (w_head == ARB_ID_DATA);
  assign rsp_rdata    = mem_rdata;

endmodule
